alarm_controller: RTL and testbench
===================================

Name: alarm_controller

Overview:
Supervisory controller for the lamp-sequence alarm detector. It arms and disarms the system, consumes the detector's alarm_bit, and times the siren. It latches alarm events and counts them. It also checks a 3-digit keypad disarm code and applies a lockout after repeated wrong entries. It sits between the detector, the keypad and the siren driver.

Parameters:
SIREN_CYCLES, 16, cycles the siren stays on after the last trigger (>=2)
DISARM_CODE, 12'h357, three 4-bit digits, entered first digit = [11:8]
MAX_TRIES, 3, consecutive wrong codes that cause lockout
LOCKOUT_CYCLES, 32, cycles keypad is ignored during lockout
CNT_W, 8, event counter width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
alarm_bit  input  1  detector output, sampled each rising edge
arm  input  1  arm request, level-sampled
key  input  4  keypad digit
key_valid  input  1  one-cycle strobe qualifying key
siren  output  1  siren drive
armed  output  1  high when state != DISARMED
latched  output  1  high in LATCHED
lockout  output  1  high while keypad is locked
event_count  output  CNT_W  number of triggers, saturating

Behaviour:
- Reset (reset=0, async): state=DISARMED, siren=0, armed=0, latched=0, lockout=0, event_count=0, digit index=0, tries=0, siren and lockout counters=0. Reset asserted mid-operation overrides everything immediately.
- All outputs are decoded from registered state, with no combinational path from inputs.
- States are DISARMED, ARMED, SIREN and LATCHED.
- DISARMED -> ARMED: arm=1 and lockout=0. arm is ignored in every other state.
- ARMED -> SIREN: alarm_bit=1. The siren counter loads SIREN_CYCLES-1. siren=1 on the first cycle in SIREN.
- SIREN: the counter decrements each cycle. alarm_bit=1 reloads it (retrigger). At counter==0 with no retrigger -> LATCHED. The siren is therefore high for exactly SIREN_CYCLES cycles after the last trigger.
- LATCHED: siren=0, latched=1. alarm_bit=1 -> SIREN (reload).
- event_count increments by 1 on every cycle with alarm_bit=1 while state is ARMED, SIREN or LATCHED. It also increments on lockout entry while ARMED. It saturates at 2^CNT_W-1. Only reset clears it.
- Code checker (active in every state):
  - Each key_valid with lockout=0 captures one digit. The mismatch flag is ORed per digit.
  - On the third digit the checker evaluates and the index returns to 0.
  - Match: pulse code_ok for 1 cycle and clear tries. The next state is DISARMED from any state, and siren, latched and the counters clear. In DISARMED a match only clears tries.
  - Mismatch: tries++. When tries reaches MAX_TRIES, lockout=1 for LOCKOUT_CYCLES cycles, tries=0 and the partial entry is discarded. If the state is ARMED, lockout entry also forces -> SIREN.
  - key_valid during lockout is ignored and does not advance the index.
- Priority in one cycle: code_ok disarm beats alarm_bit beats arm.
- alarm_bit while DISARMED has no effect and does not count.

Decomposition:
- Package alarm_pkg:
  - state enum alarm_state_t (2 bits: DISARMED, ARMED, SIREN, LATCHED)
  - digit width constant DIGIT_W=4
  - CODE_DIGITS=3
- Sub-module code_checker:
  - Parameters: DISARM_CODE, MAX_TRIES, LOCKOUT_CYCLES.
  - Outputs: code_ok and lock_start pulses, plus lockout level.
  - Contains the digit index, mismatch flag, tries counter and lockout counter.
- alarm_controller holds the main FSM, siren counter and event counter.

Test Plan:
1. Reset, then arm=1 for 1 cycle -> armed=1 next cycle; siren=0; event_count=0.
2. Armed, alarm_bit pulse 1 cycle -> siren=1 for exactly 16 cycles, then latched=1, event_count=1.
3. Retrigger: alarm_bit at siren cycle 10 -> siren stays high 16 more cycles (26 total), event_count=2.
4. Keys 3,5,7 during SIREN -> DISARMED the cycle after the 3rd key; siren=0, latched=0, armed=0. Same-cycle alarm_bit on the 3rd key is ignored.
5. Armed, three wrong codes (1,1,1 x3) -> lockout=1 for 32 cycles, siren=1, event_count+1. A valid 3,5,7 entered during lockout has no effect. After lockout, 3,5,7 disarms.
6. Assert reset=0 asynchronously mid-SIREN and mid-code-entry -> all outputs 0 immediately. After release, a fresh 3-digit entry is evaluated from digit 0.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller slice.
//   alarm_state_t : supervisory FSM state (DISARMED, ARMED, SIREN, LATCHED)
//   DIGIT_W       : keypad digit width
//   CODE_DIGITS   : digits per disarm code
package alarm_pkg;

  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned CODE_DIGITS = 3;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    SIREN    = 2'd2,
    LATCHED  = 2'd3
  } alarm_state_t;

endpackage

// File: rtl/code_checker.sv
// Keypad disarm-code checker with wrong-entry lockout.
//   clk, reset  : clock, asynchronous active-low reset
//   key         : keypad digit, qualified by key_valid
//   key_valid   : one-cycle digit strobe
//   code_ok     : pulse, the digit just accepted completed a correct code
//   lock_start  : pulse, the digit just accepted completed the final wrong try
//   lockout     : high while keypad input is ignored
module code_checker
  import alarm_pkg::*;
#(
  parameter logic [DIGIT_W*CODE_DIGITS-1:0] DISARM_CODE    = 12'h357,
  parameter int unsigned                    MAX_TRIES      = 3,
  parameter int unsigned                    LOCKOUT_CYCLES = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] key,
  input  logic               key_valid,
  output logic               code_ok,
  output logic               lock_start,
  output logic               lockout
);

  localparam int unsigned IDX_W  = $clog2(CODE_DIGITS);
  localparam int unsigned TRY_W  = $clog2(MAX_TRIES) + 1;
  localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

  logic [IDX_W-1:0]   idx_q;
  logic               mismatch_q;
  logic [TRY_W-1:0]   tries_q;
  logic [LOCK_W-1:0]  lock_cnt_q;
  logic [DIGIT_W-1:0] expected;
  logic               accept;
  logic               last_digit;
  logic               digit_bad;
  logic               entry_bad;

  // First digit entered lives in the most significant nibble of the code.
  always_comb begin
    expected = '0;
    for (int unsigned i = 0; i < CODE_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) expected = DISARM_CODE[(CODE_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
    end
  end

  assign lockout    = (lock_cnt_q != '0);
  assign accept     = key_valid && !lockout;
  assign last_digit = (idx_q == IDX_W'(CODE_DIGITS - 1));
  assign digit_bad  = (key != expected);
  assign entry_bad  = mismatch_q || digit_bad;
  assign code_ok    = accept && last_digit && !entry_bad;
  assign lock_start = accept && last_digit && entry_bad && (tries_q == TRY_W'(MAX_TRIES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q      <= '0;
      mismatch_q <= 1'b0;
      tries_q    <= '0;
      lock_cnt_q <= '0;
    end else begin
      if (accept) begin
        if (last_digit) begin
          idx_q      <= '0;
          mismatch_q <= 1'b0;
          if (code_ok || lock_start) tries_q <= '0;
          else                       tries_q <= tries_q + 1'b1;
        end else begin
          idx_q      <= idx_q + 1'b1;
          mismatch_q <= entry_bad;
        end
      end
      // Loaded with the full length so lockout is high for exactly LOCKOUT_CYCLES cycles.
      if (lock_start)   lock_cnt_q <= LOCK_W'(LOCKOUT_CYCLES);
      else if (lockout) lock_cnt_q <= lock_cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// Supervisory alarm controller: arm/disarm FSM, siren timer, event counter.
//   clk, reset  : clock, asynchronous active-low reset
//   alarm_bit   : detector output, sampled each rising edge
//   arm         : arm request, honoured only while disarmed and not locked out
//   key         : keypad digit, qualified by key_valid
//   key_valid   : one-cycle digit strobe
//   siren       : siren drive
//   armed       : system is not disarmed
//   latched     : an alarm occurred and the siren has timed out
//   lockout     : keypad locked after repeated wrong codes
//   event_count : saturating count of alarm triggers
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int unsigned                    SIREN_CYCLES   = 16,
  parameter logic [DIGIT_W*CODE_DIGITS-1:0] DISARM_CODE    = 12'h357,
  parameter int unsigned                    MAX_TRIES      = 3,
  parameter int unsigned                    LOCKOUT_CYCLES = 32,
  parameter int unsigned                    CNT_W          = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               alarm_bit,
  input  logic               arm,
  input  logic [DIGIT_W-1:0] key,
  input  logic               key_valid,
  output logic               siren,
  output logic               armed,
  output logic               latched,
  output logic               lockout,
  output logic [CNT_W-1:0]   event_count
);

  localparam int unsigned SC_W = $clog2(SIREN_CYCLES);

  alarm_state_t    state_q, state_d;
  logic [SC_W-1:0] siren_cnt_q, siren_cnt_d;
  logic            count_en;
  logic            code_ok;
  logic            lock_start;

  code_checker #(
    .DISARM_CODE    (DISARM_CODE),
    .MAX_TRIES      (MAX_TRIES),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) u_code_checker (
    .clk        (clk),
    .reset      (reset),
    .key        (key),
    .key_valid  (key_valid),
    .code_ok    (code_ok),
    .lock_start (lock_start),
    .lockout    (lockout)
  );

  // Priority: correct code, then alarm trigger (or lockout in ARMED), then arm.
  always_comb begin
    state_d     = state_q;
    siren_cnt_d = siren_cnt_q;
    count_en    = 1'b0;
    case (state_q)
      DISARMED: begin
        if (!code_ok && arm && !lockout) state_d = ARMED;
      end
      ARMED: begin
        if (code_ok) begin
          state_d     = DISARMED;
          siren_cnt_d = '0;
        end else if (alarm_bit || lock_start) begin
          state_d     = SIREN;
          siren_cnt_d = SC_W'(SIREN_CYCLES - 1);
          count_en    = 1'b1;
        end
      end
      SIREN: begin
        if (code_ok) begin
          state_d     = DISARMED;
          siren_cnt_d = '0;
        end else if (alarm_bit) begin
          siren_cnt_d = SC_W'(SIREN_CYCLES - 1);
          count_en    = 1'b1;
        end else if (siren_cnt_q == '0) begin
          state_d = LATCHED;
        end else begin
          siren_cnt_d = siren_cnt_q - 1'b1;
        end
      end
      LATCHED: begin
        if (code_ok) begin
          state_d     = DISARMED;
          siren_cnt_d = '0;
        end else if (alarm_bit) begin
          state_d     = SIREN;
          siren_cnt_d = SC_W'(SIREN_CYCLES - 1);
          count_en    = 1'b1;
        end
      end
      default: begin
        state_d     = DISARMED;
        siren_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= DISARMED;
      siren_cnt_q <= '0;
      event_count <= '0;
    end else begin
      state_q     <= state_d;
      siren_cnt_q <= siren_cnt_d;
      if (count_en && (event_count != '1)) event_count <= event_count + 1'b1;
    end
  end

  assign siren   = (state_q == SIREN);
  assign armed   = (state_q != DISARMED);
  assign latched = (state_q == LATCHED);

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed scenarios plus a
// randomized run, all compared against a behavioural model of the controller.
module tb_alarm_controller;

  localparam int SIREN_N = 16;
  localparam int LOCK_N  = 32;
  localparam int TRIES_N = 3;
  localparam int CNT_MAX = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic       alarm_bit;
  logic       arm;
  logic [3:0] key;
  logic       key_valid;
  logic       siren;
  logic       armed;
  logic       latched;
  logic       lockout;
  logic [7:0] event_count;
  logic [11:0] dut_vec;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: armed flag, "has fired" flag, remaining siren cycles,
  // typed-digit queue, wrong-try count, remaining lockout cycles.
  bit m_armed;
  bit m_fired;
  int m_siren_left;
  int m_cnt;
  int m_tries;
  int m_lock_left;
  int m_entry[$];
  int code_d[3] = '{3, 5, 7};

  alarm_controller #(
    .SIREN_CYCLES   (16),
    .DISARM_CODE    (12'h357),
    .MAX_TRIES      (3),
    .LOCKOUT_CYCLES (32),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .alarm_bit   (alarm_bit),
    .arm         (arm),
    .key         (key),
    .key_valid   (key_valid),
    .siren       (siren),
    .armed       (armed),
    .latched     (latched),
    .lockout     (lockout),
    .event_count (event_count)
  );

  always #5 clk = ~clk;

  assign dut_vec = {siren, armed, latched, lockout, event_count};

  function automatic void m_reset();
    m_armed = 0; m_fired = 0; m_siren_left = 0; m_cnt = 0;
    m_tries = 0; m_lock_left = 0;
    m_entry.delete();
  endfunction

  function automatic void m_step(input bit a, input bit ar, input int k, input bit kv);
    bit accept;
    bit ok;
    bit lock;
    bit in_armed;
    int lock_before;
    lock_before = m_lock_left;
    accept = kv && (lock_before == 0);
    ok = 0;
    lock = 0;
    if (accept) begin
      m_entry.push_back(k);
      if (m_entry.size() == 3) begin
        ok = (m_entry[0] == code_d[0]) && (m_entry[1] == code_d[1]) && (m_entry[2] == code_d[2]);
        m_entry.delete();
        if (ok) m_tries = 0;
        else begin
          m_tries++;
          if (m_tries == TRIES_N) begin
            lock = 1;
            m_tries = 0;
          end
        end
      end
    end
    if (lock) m_lock_left = LOCK_N;
    else if (m_lock_left > 0) m_lock_left--;
    in_armed = m_armed && !m_fired;
    if (ok) begin
      m_armed = 0; m_fired = 0; m_siren_left = 0;
    end else if (m_armed) begin
      if (a || (lock && in_armed)) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        m_siren_left = SIREN_N;
        m_fired = 1;
      end else if (m_siren_left > 0) begin
        m_siren_left--;
      end
    end else if (ar && lock_before == 0) begin
      m_armed = 1;
    end
  endfunction

  function automatic logic [11:0] m_vec();
    return {m_siren_left > 0, m_armed, m_armed && m_fired && (m_siren_left == 0),
            m_lock_left > 0, 8'(m_cnt)};
  endfunction

  // One clock of stimulus; the model advances on the same edge, outputs are sampled 1 unit later.
  task automatic drive(input bit a, input bit ar, input int k, input bit kv);
    alarm_bit = a; arm = ar; key = 4'(k); key_valid = kv;
    @(posedge clk);
    m_step(a, ar, k, kv);
    #1;
    alarm_bit = 0; arm = 0; key_valid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    m_reset();
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    alarm_bit = 0; arm = 0; key = 0; key_valid = 0;
    reset = 0;
    #12;
    m_reset();
    n_checks++;
    if (dut_vec !== 12'h000) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", dut_vec, 12'h000);
    end
    @(negedge clk);
    reset = 1;
    drive(0, 0, 0, 0);
    n_checks++;
    if (dut_vec !== m_vec()) begin
      n_fail++; $display("FAIL reset_idle: got %h expected %h", dut_vec, m_vec());
    end
  endtask

  task automatic test_arm();
    drive(0, 1, 0, 0);
    n_checks++;
    if ({armed, siren, event_count} !== {1'b1, 1'b0, 8'd0}) begin
      n_fail++; $display("FAIL arm: got %b/%b/%0d expected 1/0/0", armed, siren, event_count);
    end
    n_checks++;
    if (dut_vec !== m_vec()) begin
      n_fail++; $display("FAIL arm_model: got %h expected %h", dut_vec, m_vec());
    end
  endtask

  task automatic test_alarm();
    int hi;
    hi = 0;
    drive(1, 0, 0, 0);
    for (int i = 0; i < 25; i++) begin
      if (i > 0) drive(0, 0, 0, 0);
      if (siren) hi++;
      n_checks++;
      if (dut_vec !== m_vec()) begin
        n_fail++; $display("FAIL alarm_track cyc %0d: got %h expected %h", i, dut_vec, m_vec());
      end
    end
    n_checks++;
    if (hi !== SIREN_N) begin
      n_fail++; $display("FAIL siren_len: got %0d expected %0d", hi, SIREN_N);
    end
    n_checks++;
    if ({latched, event_count} !== {1'b1, 8'd1}) begin
      n_fail++; $display("FAIL alarm_latched: got %b/%0d expected 1/1", latched, event_count);
    end
  endtask

  task automatic test_retrigger();
    int hi;
    do_reset();
    drive(0, 1, 0, 0);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      // Trigger on the first cycle, retrigger during the 10th siren cycle.
      drive((i == 0) || (i == 10), 0, 0, 0);
      if (siren) hi++;
      n_checks++;
      if (dut_vec !== m_vec()) begin
        n_fail++; $display("FAIL retrig_track cyc %0d: got %h expected %h", i, dut_vec, m_vec());
      end
    end
    n_checks++;
    if (hi !== 26) begin
      n_fail++; $display("FAIL retrig_len: got %0d expected 26", hi);
    end
    n_checks++;
    if ({latched, event_count} !== {1'b1, 8'd2}) begin
      n_fail++; $display("FAIL retrig_count: got %b/%0d expected 1/2", latched, event_count);
    end
  endtask

  task automatic test_disarm();
    drive(1, 0, 0, 0);
    drive(0, 0, 3, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 5, 1);
    drive(0, 0, 0, 0);
    n_checks++;
    if (siren !== 1'b1) begin
      n_fail++; $display("FAIL disarm_pre: siren got %b expected 1", siren);
    end
    drive(1, 0, 7, 1);
    n_checks++;
    if ({siren, latched, armed, event_count} !== {3'b000, 8'd3}) begin
      n_fail++; $display("FAIL disarm: got %b%b%b/%0d expected 000/3", siren, latched, armed, event_count);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0);
      n_checks++;
      if (dut_vec !== m_vec()) begin
        n_fail++; $display("FAIL disarmed_alarm cyc %0d: got %h expected %h", i, dut_vec, m_vec());
      end
    end
  endtask

  task automatic test_lockout();
    int lock_hi;
    int keys[3] = '{3, 5, 7};
    do_reset();
    drive(0, 1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 1, 1);
      if (i < 8) drive(0, 0, 0, 0);
      n_checks++;
      if (dut_vec !== m_vec()) begin
        n_fail++; $display("FAIL wrong_key %0d: got %h expected %h", i, dut_vec, m_vec());
      end
    end
    n_checks++;
    if ({lockout, siren, event_count} !== {2'b11, 8'd1}) begin
      n_fail++; $display("FAIL lock_entry: got %b%b/%0d expected 11/1", lockout, siren, event_count);
    end
    lock_hi = 1;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, keys[i/2], (i % 2) == 0);
      if (lockout) lock_hi++;
    end
    for (int i = 0; i < 60 && lockout; i++) begin
      drive(0, 0, 0, 0);
      if (lockout) lock_hi++;
      n_checks++;
      if (dut_vec !== m_vec()) begin
        n_fail++; $display("FAIL lock_track cyc %0d: got %h expected %h", i, dut_vec, m_vec());
      end
    end
    n_checks++;
    if (lock_hi !== LOCK_N) begin
      n_fail++; $display("FAIL lock_len: got %0d expected %0d", lock_hi, LOCK_N);
    end
    n_checks++;
    if (armed !== 1'b1) begin
      n_fail++; $display("FAIL lock_ignores_code: armed got %b expected 1", armed);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, keys[i], 1);
      drive(0, 0, 0, 0);
    end
    n_checks++;
    if ({armed, lockout} !== 2'b00 || dut_vec !== m_vec()) begin
      n_fail++; $display("FAIL post_lock_disarm: got %h expected %h", dut_vec, m_vec());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(0, 1, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 3, 1);
    drive(0, 0, 5, 1);
    #3;
    reset = 0;
    #1;
    m_reset();
    n_checks++;
    if (dut_vec !== 12'h000) begin
      n_fail++; $display("FAIL async_reset: got %h expected %h", dut_vec, 12'h000);
    end
    #2;
    reset = 1;
    drive(0, 1, 0, 0);
    n_checks++;
    if (armed !== 1'b1) begin
      n_fail++; $display("FAIL rearm: armed got %b expected 1", armed);
    end
    drive(0, 0, 3, 1);
    drive(0, 0, 5, 1);
    drive(0, 0, 7, 1);
    n_checks++;
    if (armed !== 1'b0 || dut_vec !== m_vec()) begin
      n_fail++; $display("FAIL fresh_entry: got %h expected %h", dut_vec, m_vec());
    end
  endtask

  task automatic test_saturate();
    do_reset();
    drive(0, 1, 0, 0);
    for (int i = 0; i < 300; i++) begin
      drive(1, 0, 0, 0);
      n_checks++;
      if (dut_vec !== m_vec()) begin
        n_fail++; $display("FAIL sat_track cyc %0d: got %h expected %h", i, dut_vec, m_vec());
      end
    end
    n_checks++;
    if (event_count !== 8'd255) begin
      n_fail++; $display("FAIL saturate: got %0d expected 255", event_count);
    end
  endtask

  task automatic test_random();
    int r;
    int k;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 4);
      k = (r < 3) ? code_d[r] : $urandom_range(0, 15);
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0, k, $urandom_range(0, 2) == 0);
      n_checks++;
      if (dut_vec !== m_vec()) begin
        n_fail++; $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec, m_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_arm();
    test_alarm();
    test_retrigger();
    test_disarm();
    test_lockout();
    test_async_reset();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
